// File: rtl/mdu_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdu_div : radix-2 restoring divider for MIPS DIV/DIVU (quotient->lo, rem->hi)
// Optional: MDU_DIV_ZERO_DETECT_EN (early exit with div_zero flag when b==0)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
`ifdef MDU_DIV_ZERO_DETECT_EN
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
`endif

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // Partial remainder is 33 bits wide; the dividend shifts out of quo_q MSB-first.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};
  assign qbit      = ~rem_diff[WIDTH];
  assign rem_next  = qbit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo_q[WIDTH-2:0], qbit};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
`ifdef MDU_DIV_ZERO_DETECT_EN
    zero_d  = zero_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          state_d = BUSY;
          count_d = '0;
          rem_d   = '0;
          quo_d   = (is_signed && a[WIDTH-1]) ? -a : a;
          dvs_d   = (is_signed && b[WIDTH-1]) ? -b : b;
          negq_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d  = is_signed & a[WIDTH-1];
`ifdef MDU_DIV_ZERO_DETECT_EN
          dz_d    = 1'b0;
          zero_d  = (b == '0);
          if (b == '0) quo_d = a;
`endif
        end
      end
      BUSY: begin
`ifdef MDU_DIV_ZERO_DETECT_EN
        if (zero_q) begin
          state_d = DONE;
          lo_d    = '1;
          hi_d    = quo_q;
          dz_d    = 1'b1;
        end else
`endif
        begin
          count_d = count_q + CW'(1);
          rem_d   = rem_next;
          quo_d   = quo_next;
          // Sign fix-up is folded into the completion write.
          if (count_q == LAST) begin
            state_d = DONE;
            lo_d    = negq_q ? -quo_next : quo_next;
            hi_d    = negr_q ? -rem_next : rem_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (cancel) begin
      state_d = IDLE;
      lo_d    = lo_q;
      hi_d    = hi_q;
`ifdef MDU_DIV_ZERO_DETECT_EN
      dz_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
`ifdef MDU_DIV_ZERO_DETECT_EN
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
`ifdef MDU_DIV_ZERO_DETECT_EN
      zero_q  <= zero_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy  = (state_q == BUSY);
  assign valid = (state_q == DONE);
  assign lo    = lo_q;
  assign hi    = hi_q;
`ifdef MDU_DIV_ZERO_DETECT_EN
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mdu_div.sv
`default_nettype none
// tb_mdu_div : scoreboard bench for mdu_div (results, latency, control corners).
module tb_mdu_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, valid, div_zero;
  logic [31:0] lo, hi;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          busy_cyc = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  mdu_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .cancel(cancel), .busy(busy), .valid(valid),
    .lo(lo), .hi(hi), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input bit sgn, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    int   da, db;
    e.dz  = 1'b0;
    e.cyc = 0;
    if (bv == 32'd0) begin
`ifdef MDU_DIV_ZERO_DETECT_EN
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
`else
      e.lo = (sgn && av[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
      e.hi = av;
    end else if (!sgn) begin
      e.lo = av / bv;
      e.hi = av % bv;
    end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'd0;
    end else begin
      da   = av;
      db   = bv;
      e.lo = da / db;
      e.hi = da % db;
    end
    return e;
  endfunction

  task automatic raw_start(input bit sgn, input logic [31:0] av, input logic [31:0] bv);
    start     = 1'b1;
    is_signed = sgn;
    a         = av;
    b         = bv;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic launch(input bit sgn, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    e = model(sgn, av, bv);
`ifdef MDU_DIV_ZERO_DETECT_EN
    e.cyc = cyc + ((bv == 32'd0) ? 2 : 33);
`else
    e.cyc = cyc + 33;
`endif
    sb.push_back(e);
    raw_start(sgn, av, bv);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Output monitor: every valid pulse must match the oldest pending expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (busy) busy_cyc++;
    if (valid && !rst) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("lo", lo, e.lo);
        check("hi", hi, e.hi);
        check("div_zero", 32'(div_zero), 32'(e.dz));
        check("latency", 32'(cyc), 32'(e.cyc));
        last_lo = e.lo;
        last_hi = e.hi;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);

    busy_cyc = 0;
    launch(1'b0, 32'd100, 32'd7);
    wait_drain();
    check("busy_cycles", 32'(busy_cyc), 32'd32);

    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_drain();
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_drain();
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_drain();

    // Second start while busy must be ignored.
    launch(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    raw_start(1'b0, 32'd9, 32'd3);
    wait_drain();

    // Cancel mid-operation.
    raw_start(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("cancel_lo", lo, last_lo);
    check("cancel_hi", hi, last_hi);

    // Back-to-back: new start in the DONE cycle.
    launch(1'b1, 32'hFFFF_FF9C, 32'd7);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("b2b_valid_seen", 32'(seen), 32'd1);
      if (seen) launch(1'b0, 32'd1000, 32'd33);
    end
    wait_drain();

    launch(1'b0, 32'h1234_5678, 32'd0);
    wait_drain();
    launch(1'b1, 32'hFFFF_FFFB, 32'd0);
    wait_drain();

    // Reset mid-operation.
    raw_start(1'b0, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_lo", lo, 32'd0);
    check("mrst_hi", hi, 32'd0);
    check("mrst_dz", 32'(div_zero), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    launch(1'b0, 32'd100, 32'd7);
    wait_drain();

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 4 == 1) rb = -rb;
      launch(1'(i % 2), ra, rb);
      wait_drain();
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
